// File: rtl/pin_controller_pkg.sv
// pin_controller shared definitions:
// register offsets, mode encodings, FSM states.
package pin_controller_pkg;

  localparam logic [7:0] REG_CMD   = 8'h00;
  localparam logic [7:0] REG_HIGH  = 8'h01;
  localparam logic [7:0] REG_LOW   = 8'h02;
  localparam logic [7:0] REG_DIV   = 8'h03;
  localparam logic [7:0] REG_SCNT  = 8'h10;
  localparam logic [7:0] REG_SWORD = 8'h11;
  localparam logic [7:0] REG_ECNT  = 8'h12;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_CONST  = 2'd1,
    MODE_SQUARE = 2'd2,
    MODE_RECORD = 2'd3
  } mode_e;

  localparam logic [2:0] ST_OFF     = 3'd0;
  localparam logic [2:0] ST_CONST   = 3'd1;
  localparam logic [2:0] ST_SQ_HIGH = 3'd2;
  localparam logic [2:0] ST_SQ_LOW  = 3'd3;
  localparam logic [2:0] ST_RECORD  = 3'd4;

endpackage

// File: rtl/pin_controller_if.sv
// Scheduler command bus as seen by one pin_controller.
// master = scheduler side, slave = pin side.
interface pin_controller_if;

  logic [15:0] bus_addr;
  logic [31:0] bus_data;
  logic        bus_en;
  logic        bus_wr;
  logic        bus_rd;
  logic [31:0] bus_rdata;
  logic        bus_rdata_valid;

  modport master (
    output bus_addr, bus_data,
    output bus_en, bus_wr, bus_rd,
    input  bus_rdata, bus_rdata_valid
  );

  modport slave (
    input  bus_addr, bus_data,
    input  bus_en, bus_wr, bus_rd,
    output bus_rdata, bus_rdata_valid
  );

endinterface

// File: rtl/pin_sync.sv
// 2-flop synchronizer for asynchronous pin inputs.
// Async active-high reset, clears to 0.
module pin_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/pin_controller.sv
// Per-pin controller: off/const/square/record modes.
// Optional rising-edge counter: PIN_CONTROLLER_EDGE_COUNT_EN.
module pin_controller
  import pin_controller_pkg::*;
#(
  parameter logic [7:0] POSITION = 8'd0,
  parameter int         CNT_W    = 32
) (
  input  logic clk,
  input  logic rst,
  pin_controller_if.slave bus,
  input  logic pin_in,
  output logic pin_out,
  output logic pin_oe
);

  localparam logic [CNT_W-1:0] ONE = 1;

  logic             hit;
  logic             wr_hit;
  logic             rd_hit;
  logic             cmd_wr;
  logic [7:0]       off;
  mode_e            mode;
  logic             pin_s;

  logic [CNT_W-1:0] high_time;
  logic [CNT_W-1:0] low_time;
  logic [CNT_W-1:0] sample_div;
  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      sample_cnt;
  logic [31:0]      sample_word;
  logic [31:0]      edge_val;
  logic [31:0]      read_val;

  assign off    = bus.bus_addr[7:0];
  assign hit    = bus.bus_en &&
                  (bus.bus_addr[15:8] == POSITION);
  assign wr_hit = hit & bus.bus_wr;
  assign rd_hit = hit & bus.bus_rd & ~bus.bus_wr;
  assign cmd_wr = wr_hit && (off == REG_CMD);
  assign mode   = mode_e'(bus.bus_data[1:0]);

  // A zero phase length still lasts one cycle.
  function automatic logic [CNT_W-1:0] ph_load(
    input logic [CNT_W-1:0] t
  );
    return (t == '0) ? '0 : t - ONE;
  endfunction

  pin_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (pin_in),
    .q   (pin_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      high_time  <= '0;
      low_time   <= '0;
      sample_div <= '0;
    end else if (wr_hit) begin
      unique case (1'b1)
        (off == REG_HIGH):
          high_time <= bus.bus_data[CNT_W-1:0];
        (off == REG_LOW):
          low_time <= bus.bus_data[CNT_W-1:0];
        (off == REG_DIV):
          sample_div <= bus.bus_data[CNT_W-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_OFF;
      cnt         <= '0;
      pin_out     <= 1'b0;
      pin_oe      <= 1'b0;
      sample_cnt  <= '0;
      sample_word <= '0;
    end else if (cmd_wr) begin
      unique case (mode)
        MODE_OFF: begin
          state   <= ST_OFF;
          cnt     <= '0;
          pin_oe  <= 1'b0;
          pin_out <= 1'b0;
        end
        MODE_CONST: begin
          state   <= ST_CONST;
          cnt     <= '0;
          pin_oe  <= 1'b1;
          pin_out <= bus.bus_data[8];
        end
        MODE_SQUARE: begin
          state   <= ST_SQ_HIGH;
          cnt     <= ph_load(high_time);
          pin_oe  <= 1'b1;
          pin_out <= 1'b1;
        end
        MODE_RECORD: begin
          state       <= ST_RECORD;
          cnt         <= sample_div;
          pin_oe      <= 1'b0;
          pin_out     <= 1'b0;
          sample_cnt  <= '0;
          sample_word <= '0;
        end
      endcase
    end else begin
      case (state)
        ST_SQ_HIGH: begin
          if (cnt == '0) begin
            state   <= ST_SQ_LOW;
            pin_out <= 1'b0;
            cnt     <= ph_load(low_time);
          end else begin
            cnt <= cnt - ONE;
          end
        end
        ST_SQ_LOW: begin
          if (cnt == '0) begin
            state   <= ST_SQ_HIGH;
            pin_out <= 1'b1;
            cnt     <= ph_load(high_time);
          end else begin
            cnt <= cnt - ONE;
          end
        end
        ST_RECORD: begin
          if (cnt == '0) begin
            sample_word <= {sample_word[30:0], pin_s};
            sample_cnt  <= sample_cnt + 32'd1;
            cnt         <= sample_div;
          end else begin
            cnt <= cnt - ONE;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef PIN_CONTROLLER_EDGE_COUNT_EN
  logic        pin_q;
  logic [31:0] edge_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pin_q    <= 1'b0;
      edge_cnt <= '0;
    end else begin
      pin_q <= pin_s;
      if (wr_hit && (off == REG_ECNT))
        edge_cnt <= '0;
      else if (pin_s & ~pin_q)
        edge_cnt <= edge_cnt + 32'd1;
    end
  end

  assign edge_val = edge_cnt;
`else
  assign edge_val = '0;
`endif

  always_comb begin
    read_val = '0;
    unique case (1'b1)
      (off == REG_SCNT):  read_val = sample_cnt;
      (off == REG_SWORD): read_val = sample_word;
      (off == REG_ECNT):  read_val = edge_val;
      default: ;
    endcase
  end

  // Reads see register values from before this edge's update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.bus_rdata       <= '0;
      bus.bus_rdata_valid <= 1'b0;
    end else begin
      bus.bus_rdata_valid <= rd_hit;
      if (rd_hit)
        bus.bus_rdata <= read_val;
    end
  end

endmodule

// File: tb/tb_pin_controller.sv
// Self-checking bench for pin_controller (POSITION=3).
// Reference model works from pin history and phase arithmetic.
module tb_pin_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pin_in = 1'b0;
  logic pin_out;
  logic pin_oe;

  pin_controller_if bif ();

  pin_controller #(.POSITION(8'd3)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bif),
    .pin_in  (pin_in),
    .pin_out (pin_out),
    .pin_oe  (pin_oe)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int edge_no = 0;
  logic hist [0:8191];

  // hist[n] = pin_in value seen at posedge number n
  always @(posedge clk) begin
    hist[edge_no] = pin_in;
    edge_no++;
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_bus;
    bif.bus_en   = 1'b0;
    bif.bus_wr   = 1'b0;
    bif.bus_rd   = 1'b0;
    bif.bus_addr = '0;
    bif.bus_data = '0;
  endtask

  // Drives one bus cycle; e = index of the capturing posedge.
  task automatic bus_op(input logic [15:0] a,
                        input logic [31:0] d,
                        input logic w, input logic r,
                        output int e);
    @(negedge clk);
    bif.bus_en   = 1'b1;
    bif.bus_wr   = w;
    bif.bus_rd   = r;
    bif.bus_addr = a;
    bif.bus_data = d;
    e = edge_no;
    @(negedge clk);
    idle_bus();
  endtask

  task automatic wr(input logic [15:0] a,
                    input logic [31:0] d,
                    output int e);
    bus_op(a, d, 1'b1, 1'b0, e);
  endtask

  task automatic rd(input logic [15:0] a,
                    output logic [31:0] data,
                    output int e);
    bus_op(a, '0, 1'b0, 1'b1, e);
    check("rd_valid", bif.bus_rdata_valid, 1);
    data = bif.bus_rdata;
  endtask

  // Samples land at e+(d+1)k; each takes the pin value from two
  // edges earlier; a read at edge r sees samples before r.
  function automatic void rec_model(input int e, input int d,
                                    input int r,
                                    output logic [31:0] cnt,
                                    output logic [31:0] word);
    cnt  = '0;
    word = '0;
    for (int q = e + d + 1; q < r; q += d + 1) begin
      word = {word[30:0], hist[q-2]};
      cnt  = cnt + 1;
    end
  endfunction

  initial begin
    int e, r, r2, dum, k, h, l, hp, lp, d;
    logic [31:0] data, mc, mw, exp_ec;

    idle_bus();
    repeat (3) @(negedge clk);
    check("rst_oe", pin_oe, 0);
    check("rst_out", pin_out, 0);
    check("rst_valid", bif.bus_rdata_valid, 0);
    check("rst_rdata", bif.bus_rdata, 0);
    rst = 1'b0;

    rd(16'h0310, data, dum);
    check("rd_scnt_reset", data, 0);
    @(negedge clk);
    check("valid_pulse", bif.bus_rdata_valid, 0);

    wr(16'h0300, 32'h101, dum);
    check("const1_oe", pin_oe, 1);
    check("const1_out", pin_out, 1);
    wr(16'h0400, 32'h000, dum);
    check("nohit_oe", pin_oe, 1);
    check("nohit_out", pin_out, 1);
    wr(16'h0300, 32'h001, dum);
    check("const0_oe", pin_oe, 1);
    check("const0_out", pin_out, 0);

    bus_op(16'h0300, 32'h0, 1'b1, 1'b1, dum);
    check("rdwr_valid", bif.bus_rdata_valid, 0);
    check("rdwr_oe", pin_oe, 0);

    wr(16'h0301, 32'd3, dum);
    rd(16'h0301, data, dum);
    check("rd_unmapped", data, 0);

    wr(16'h0302, 32'd2, dum);
    wr(16'h0300, 32'd2, e);
    for (int i = 0; i < 15; i++) begin
      k = edge_no - 1 - e;
      check("sq_3_2", pin_out, ((k % 5) < 3) ? 1 : 0);
      @(negedge clk);
    end

    wr(16'h0302, 32'd2, dum);
    wr(16'h0300, 32'd2, e);
    wr(16'h0302, 32'd5, dum);
    for (int i = 0; i < 18; i++) begin
      k = edge_no - 1 - e;
      if (k < 3)
        check("sq_midwr", pin_out, 1);
      else
        check("sq_midwr", pin_out,
              (((k - 3) % 8) < 5) ? 0 : 1);
      @(negedge clk);
    end

    wr(16'h0301, 32'd0, dum);
    wr(16'h0302, 32'd0, dum);
    wr(16'h0300, 32'd2, e);
    for (int i = 0; i < 8; i++) begin
      k = edge_no - 1 - e;
      check("sq_toggle", pin_out, (k % 2 == 0) ? 1 : 0);
      @(negedge clk);
    end

    for (int it = 0; it < 3; it++) begin
      h  = $urandom_range(0, 6);
      l  = $urandom_range(0, 6);
      hp = (h == 0) ? 1 : h;
      lp = (l == 0) ? 1 : l;
      wr(16'h0301, h, dum);
      wr(16'h0302, l, dum);
      wr(16'h0300, 32'd2, e);
      for (int i = 0; i < 14; i++) begin
        k = edge_no - 1 - e;
        check("sq_rand_oe", pin_oe, 1);
        check("sq_rand", pin_out,
              ((k % (hp + lp)) < hp) ? 1 : 0);
        @(negedge clk);
      end
    end

    pin_in = 1'b1;
    wr(16'h0303, 32'd1, dum);
    wr(16'h0300, 32'd3, e);
    check("rec_oe", pin_oe, 0);
    repeat (19) @(negedge clk);
    rd(16'h0311, data, r);
    rec_model(e, 1, r, mc, mw);
    check("rec_word_lit", data, 32'h3FF);
    check("rec_word_mdl", data, mw);
    rd(16'h0310, data, r2);
    rec_model(e, 1, r2, mc, mw);
    check("rec_cnt_mdl", data, mc);

    @(negedge clk);
    #2 rst = 1'b1;
    #1 check("async_rdata", bif.bus_rdata, 0);
    check("async_oe", pin_oe, 0);
    @(negedge clk);
    rst = 1'b0;
    rd(16'h0310, data, dum);
    check("rec_cnt_after_rst", data, 0);

    for (int it = 0; it < 3; it++) begin
      d = $urandom_range(0, 3);
      wr(16'h0303, d, dum);
      wr(16'h0300, 32'd3, e);
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        pin_in = $urandom_range(0, 1);
      end
      rd(16'h0310, data, r);
      rec_model(e, d, r, mc, mw);
      check("rec_rand_cnt", data, mc);
      rd(16'h0311, data, r);
      rec_model(e, d, r, mc, mw);
      check("rec_rand_word", data, mw);
    end

`ifdef PIN_CONTROLLER_EDGE_COUNT_EN
    exp_ec = 32'd5;
`else
    exp_ec = 32'd0;
`endif
    pin_in = 1'b0;
    repeat (4) @(negedge clk);
    wr(16'h0312, 32'h0, dum);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      pin_in = 1'b1;
      repeat (2) @(negedge clk);
      pin_in = 1'b0;
      repeat (2) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    rd(16'h0312, data, dum);
    check("edge_cnt", data, exp_ec);
    wr(16'h0312, 32'h1234, dum);
    rd(16'h0312, data, dum);
    check("edge_clr", data, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
